writeback_stage: RTL
====================

# writeback_stage

Final (writeback) stage of the 3-stage RV32I pipeline. It registers execute-stage results and runs a small load FSM against the data-memory response port. It performs byte/half-word alignment and sign/zero extension for loads, then drives the register file write port (`reg_wr_DE`, `waddrDE`, `wdata`). While a load is outstanding it asserts `stall` to freeze upstream stages.

## Interface
Parameters:
- `XLEN`, 32, datapath width.

Ports:
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  execute stage presents an instruction this cycle.
- `ex_reg_wr`  in  1  instruction writes rd.
- `ex_rd`  in  5  destination register.
- `ex_wb_sel`  in  2  result source: 0 ALU, 1 load, 2 PC+4, 3 reserved (treated as ALU).
- `ex_funct3`  in  3  load size/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101).
- `ex_alu_result`  in  XLEN  ALU result / load effective address.
- `ex_pc`  in  XLEN  instruction PC.
- `dmem_req`  out  1  load request strobe.
- `dmem_addr`  out  XLEN  word-aligned load address.
- `dmem_rvalid`  in  1  load data valid.
- `dmem_rdata`  in  XLEN  load word.
- `stall`  out  1  hold upstream stages.
- `reg_wr_DE`  out  1  register file write enable.
- `waddrDE`  out  5  register file write address.
- `wdata`  out  XLEN  register file write data.
- `misalign`  out  1  misaligned-load pulse (see Configuration).

## Operation
- FSM states: IDLE, WAIT_MEM.
- IDLE, `ex_valid`=1, `ex_wb_sel`≠1:
  - Capture on the next edge: `waddrDE`=`ex_rd`; `reg_wr_DE`=`ex_reg_wr && ex_rd!=0`.
  - `wdata`=`ex_alu_result`, or `ex_pc+4` for sel 2 (mod 2^32 wrap).
  - Stay in IDLE.
- IDLE, `ex_valid`=1, `ex_wb_sel`=1:
  - `dmem_req`=1 combinationally; `dmem_addr`={`ex_alu_result[31:2]`,2'b00}.
  - Latch rd, reg_wr, funct3 and addr[1:0]; go to WAIT_MEM.
  - `reg_wr_DE`=0 on the next cycle.
- WAIT_MEM:
  - `stall`=1 (combinational from state).
  - `dmem_req`=0; `ex_*` inputs ignored.
  - On `dmem_rvalid`=1: format data through `load_align`, register into `wdata`, set `reg_wr_DE` per latched rd/reg_wr, return to IDLE.
- Load formatting:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - Sign extension for LB/LH; zero extension for LBU/LHU.
  - funct3 011/110/111 are treated as LW.
- `dmem_rvalid` in IDLE is ignored.
- `ex_valid`=0 in IDLE: `reg_wr_DE`=0 next cycle.
- rd=x0: `reg_wr_DE` is never asserted.

## Timing
- Reset values: `reg_wr_DE`=0, `waddrDE`=0, `wdata`=0, `stall`=0, `dmem_req`=0, `dmem_addr`=0, `misalign`=0. FSM resets to IDLE.
- ALU/PC+4 latency: 1 cycle.
  - Written at edge N, visible on outputs during cycle N.
  - The register file commits on that cycle's falling edge.
- Load latency: 1 + response delay.
  - `dmem_rvalid` sampled at edge M gives a write visible in cycle M.
  - `stall` deasserts in the same cycle.
- `dmem_rvalid` is not sampled in the request cycle; the minimum response is the next cycle.
- `reg_wr_DE` is high for exactly one cycle per instruction.
- Reset asserted in WAIT_MEM: immediate return to IDLE with outputs cleared. A late `dmem_rvalid` after reset is dropped.

## Configuration
- `WB_MISALIGN_CHK_EN` defined:
  - A load with LH/LHU and addr[0]=1, or LW and addr[1:0]≠0, issues no `dmem_req` and stays in IDLE.
  - `reg_wr_DE`=0 next cycle; `misalign` pulses 1 cycle.
- Undefined:
  - `misalign` is tied 0.
  - Misaligned addresses are issued word-aligned; bytes are selected by addr[1:0] (half uses addr[1]).

## Structure
- `wb_pkg`: `wb_sel_e` enum (WB_ALU, WB_MEM, WB_PC4, WB_RSVD), load funct3 localparams, `wb_state_e` (IDLE, WAIT_MEM).
- Sub-module `load_align`: combinational byte/half select plus extend. Inputs funct3, addr[1:0], rdata; output XLEN.

## Test plan
- ALU op, rd=5, `ex_alu_result`=0x1234_5678 → next cycle `reg_wr_DE`=1, `waddrDE`=5, `wdata`=0x1234_5678, `stall`=0.
- PC+4 with `ex_pc`=0xFFFF_FFFC, rd=1 → `wdata`=0x0000_0000 (wrap).
- LB at addr 0x103, `dmem_rvalid` after 3 cycles with rdata 0x80FF_0000 → `dmem_addr`=0x100; `stall` high for 3 cycles; then `wdata`=0xFFFF_FF80. The same with LBU → 0x0000_0080.
- ALU op with rd=0, `ex_reg_wr`=1 → `reg_wr_DE` stays 0.
- Reset asserted mid WAIT_MEM, `dmem_rvalid` pulsed after release → no write, FSM in IDLE, `stall`=0.
- With `WB_MISALIGN_CHK_EN`: LW at 0x102 → `dmem_req`=0, `misalign` 1-cycle pulse, `reg_wr_DE`=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the RV32I writeback stage: result-source select,
// load funct3 codes, load FSM states and a load alignment helper.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Unlisted funct3 codes behave as LW, so they need word alignment.
    function automatic logic ld_misaligned(logic [2:0] f3, logic [1:0] a);
        logic m;
        unique case (1'b1)
            (f3 == F3_LB || f3 == F3_LBU): m = 1'b0;
            (f3 == F3_LH || f3 == F3_LHU): m = a[0];
            default:                       m = (a != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Data-memory load response port between writeback stage and memory.
// master: dmem_req/dmem_addr out, dmem_rvalid/dmem_rdata in; slave: reverse.
interface writeback_stage_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic [XLEN-1:0] dmem_addr;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_addr,
        input  dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_addr,
        output dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/load_align.sv
// Load formatter: picks byte (addr[1:0]) or half (addr[1]) from the word
// and sign/zero extends. Ports: funct3_i, addr_i, rdata_i in; data_o out.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o
);
    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        byte_w = rdata_i[{addr_i, 3'b000} +: 8];
        half_w = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o = rdata_i;
        unique case (1'b1)
            (funct3_i == F3_LB):  data_o = {{(XLEN-8){byte_w[7]}}, byte_w};
            (funct3_i == F3_LBU): data_o = {{(XLEN-8){1'b0}}, byte_w};
            (funct3_i == F3_LH):  data_o = {{(XLEN-16){half_w[15]}}, half_w};
            (funct3_i == F3_LHU): data_o = {{(XLEN-16){1'b0}}, half_w};
            default:              data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// RV32I writeback stage: registers ALU/PC+4 results, runs the load FSM
// against the dmem port and drives the register file write port.
// Ports: clk, rst (async active-low), ex_* from execute, dmem (master),
// stall, reg_wr_DE/waddrDE/wdata, misalign.
// Option: WB_MISALIGN_CHK_EN drops misaligned LH/LHU/LW and pulses misalign.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic               ex_reg_wr,
    input  logic [4:0]         ex_rd,
    input  logic [1:0]         ex_wb_sel,
    input  logic [2:0]         ex_funct3,
    input  logic [XLEN-1:0]    ex_alu_result,
    input  logic [XLEN-1:0]    ex_pc,
    writeback_stage_if.master  dmem,
    output logic               stall,
    output logic               reg_wr_DE,
    output logic [4:0]         waddrDE,
    output logic [XLEN-1:0]    wdata,
    output logic               misalign
);
    wb_state_e       state_q;
    logic [4:0]      rd_q;
    logic            wr_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic            reg_wr_q;
    logic [4:0]      waddr_q;
    logic [XLEN-1:0] wdata_q;
    logic            misalign_q;

    wb_sel_e         sel;
    logic            is_load;
    logic            mis_chk;
    logic            wr_en;
    logic [XLEN-1:0] res_d;
    logic [XLEN-1:0] ld_d;

    assign sel     = wb_sel_e'(ex_wb_sel);
    assign is_load = (state_q == IDLE) && ex_valid && (sel == WB_MEM);
    assign wr_en   = ex_reg_wr && (ex_rd != 5'd0);
    assign res_d   = (sel == WB_PC4) ? ex_pc + XLEN'(4) : ex_alu_result;

`ifdef WB_MISALIGN_CHK_EN
    assign mis_chk = ld_misaligned(ex_funct3, ex_alu_result[1:0]);
`else
    assign mis_chk = 1'b0;
`endif

    // Request is gated by reset so the port is quiet while held in reset.
    assign dmem.dmem_req  = rst && is_load && !mis_chk;
    assign dmem.dmem_addr = dmem.dmem_req ?
                            {ex_alu_result[XLEN-1:2], 2'b00} : '0;

    load_align #(.XLEN(XLEN)) u_align (
        .funct3_i (f3_q),
        .addr_i   (off_q),
        .rdata_i  (dmem.dmem_rdata),
        .data_o   (ld_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            wr_q       <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            reg_wr_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            reg_wr_q   <= 1'b0;
            misalign_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ex_valid && sel == WB_MEM) begin
                        if (mis_chk) begin
                            misalign_q <= 1'b1;
                        end else begin
                            rd_q    <= ex_rd;
                            wr_q    <= wr_en;
                            f3_q    <= ex_funct3;
                            off_q   <= ex_alu_result[1:0];
                            state_q <= WAIT_MEM;
                        end
                    end else if (ex_valid) begin
                        waddr_q  <= ex_rd;
                        reg_wr_q <= wr_en;
                        wdata_q  <= res_d;
                    end
                end
                WAIT_MEM: begin
                    if (dmem.dmem_rvalid) begin
                        waddr_q  <= rd_q;
                        reg_wr_q <= wr_q;
                        wdata_q  <= ld_d;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall     = (state_q == WAIT_MEM);
    assign reg_wr_DE = reg_wr_q;
    assign waddrDE   = waddr_q;
    assign wdata     = wdata_q;
    assign misalign  = misalign_q;
endmodule
